// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants, entry type and BHT index helper for branch resolution
package bp_pkg;

   localparam int PC_W  = 32;
   localparam int IDX_W = 5;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic            pred;
      logic [PC_W-1:0] pred_target;
   } bp_entry_t;

   // Word-aligned PCs: drop the two byte-offset bits, keep the next IDX_W bits
   function automatic logic [IDX_W-1:0] bht_index(input logic [PC_W-1:0] pc);
      return IDX_W'(pc >> 2);
   endfunction

endpackage

// File: rtl/pred_fifo.sv
// rtl/pred_fifo.sv - synchronous in-order FIFO holding in-flight branch predictions
module pred_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clear,
   input  logic [W-1:0]               wdata,
   output logic [W-1:0]               rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Clear wins over push: a cleared FIFO never keeps a same-cycle write
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - tracks fetched predictions, resolves them, trains the BHT and flushes on mispredict
module branch_resolve_unit
   import bp_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_valid,
   input  logic [PC_W-1:0]  if_pc,
   input  logic             if_pred,
   input  logic [PC_W-1:0]  if_pred_target,
   output logic             if_stall,
   input  logic             ex_valid,
   input  logic             ex_taken,
   input  logic [PC_W-1:0]  ex_target,
   output logic             bht_en,
   output logic [IDX_W-1:0] bht_write_addr,
   output logic             bht_was_taken,
   output logic             flush,
   output logic [PC_W-1:0]  redirect_pc,
   output logic             err_underflow,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam int CW = $clog2(DEPTH+1);

   bp_entry_t                    wr_entry;
   bp_entry_t                    head;
   logic [$bits(bp_entry_t)-1:0] head_bits;
   logic [CW-1:0]                count;
   logic                         full;
   logic                         empty;
   logic                         resolve;
   logic                         mispredict;
   logic                         push;

   assign wr_entry   = '{pc: if_pc, pred: if_pred, pred_target: if_pred_target};
   assign head       = bp_entry_t'(head_bits);
   assign if_stall   = (count == CW'(DEPTH));
   assign resolve    = ex_valid && !empty;
   assign mispredict = resolve &&
                       ((head.pred != ex_taken) || (ex_taken && (head.pred_target != ex_target)));
   // Anything fetched alongside a mispredict is wrong-path and must not enter
   assign push       = if_valid && !full && !mispredict;

   pred_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(bp_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (resolve),
      .clear (mispredict),
      .wdata (wr_entry),
      .rdata (head_bits),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         bht_en         <= 1'b0;
         bht_write_addr <= '0;
         bht_was_taken  <= 1'b0;
         flush          <= 1'b0;
         redirect_pc    <= '0;
         err_underflow  <= 1'b0;
         branch_cnt     <= '0;
         mispred_cnt    <= '0;
      end else begin
         bht_en <= resolve;
         flush  <= mispredict;
         if (resolve) begin
            bht_write_addr <= bht_index(head.pc);
            bht_was_taken  <= ex_taken;
            if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
         end
         if (mispredict) begin
            redirect_pc <= ex_taken ? ex_target : head.pc + PC_W'(4);
            if (mispred_cnt != '1) mispred_cnt <= mispred_cnt + CNT_W'(1);
         end
         if (ex_valid && empty) err_underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed and randomized checks of branch_resolve_unit against a queue model
module tb_branch_resolve_unit;

   localparam int DEPTH = 4;
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [31:0] if_pc;
   logic        if_pred;
   logic [31:0] if_pred_target;
   logic        if_stall;
   logic        ex_valid;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        bht_en;
   logic [4:0]  bht_write_addr;
   logic        bht_was_taken;
   logic        flush;
   logic [31:0] redirect_pc;
   logic        err_underflow;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] mispred_cnt;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] pc;
      logic        pred;
      logic [31:0] tgt;
   } m_entry_t;

   m_entry_t   q[$];
   logic             e_bht_en;
   logic [4:0]       e_addr;
   logic             e_wt;
   logic             e_flush;
   logic [31:0]      e_redir;
   logic             e_err;
   logic [CNT_W-1:0] e_bcnt;
   logic [CNT_W-1:0] e_mcnt;

   always #5 clk = ~clk;

   branch_resolve_unit #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_pred        (if_pred),
      .if_pred_target (if_pred_target),
      .if_stall       (if_stall),
      .ex_valid       (ex_valid),
      .ex_taken       (ex_taken),
      .ex_target      (ex_target),
      .bht_en         (bht_en),
      .bht_write_addr (bht_write_addr),
      .bht_was_taken  (bht_was_taken),
      .flush          (flush),
      .redirect_pc    (redirect_pc),
      .err_underflow  (err_underflow),
      .branch_cnt     (branch_cnt),
      .mispred_cnt    (mispred_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      e_bht_en = 1'b0;
      e_flush  = 1'b0;
      e_err    = 1'b0;
      e_bcnt   = '0;
      e_mcnt   = '0;
   endtask

   task automatic check_outputs();
      chk("bht_en", bht_en, e_bht_en);
      chk("flush", flush, e_flush);
      if (e_bht_en) begin
         chk("bht_write_addr", bht_write_addr, e_addr);
         chk("bht_was_taken", bht_was_taken, e_wt);
      end
      if (e_flush) chk("redirect_pc", redirect_pc, e_redir);
      chk("err_underflow", err_underflow, e_err);
      chk("branch_cnt", branch_cnt, e_bcnt);
      chk("mispred_cnt", mispred_cnt, e_mcnt);
   endtask

   // One clock: drive inputs, predict from the queue model, compare after the edge
   task automatic step(input logic iv, input logic [31:0] pc, input logic pr, input logic [31:0] pt,
                       input logic ev, input logic tk, input logic [31:0] tg);
      bit       stall_m;
      bit       mis;
      m_entry_t h;
      if_valid       = iv;
      if_pc          = pc;
      if_pred        = pr;
      if_pred_target = pt;
      ex_valid       = ev;
      ex_taken       = tk;
      ex_target      = tg;
      #1;
      stall_m = (q.size() == DEPTH);
      chk("if_stall", if_stall, stall_m);
      e_bht_en = 1'b0;
      e_flush  = 1'b0;
      mis      = 1'b0;
      if (ev) begin
         if (q.size() == 0) begin
            e_err = 1'b1;
         end else begin
            h   = q[0];
            mis = (h.pred != tk) || (tk && (h.tgt != tg));
            e_bht_en = 1'b1;
            e_addr   = h.pc[6:2];
            e_wt     = tk;
            if (e_bcnt != CNT_MAX) e_bcnt = e_bcnt + 1'b1;
            if (mis) begin
               e_flush = 1'b1;
               e_redir = tk ? tg : h.pc + 32'd4;
               q.delete();
               if (e_mcnt != CNT_MAX) e_mcnt = e_mcnt + 1'b1;
            end else begin
               void'(q.pop_front());
            end
         end
      end
      if (iv && !stall_m && !mis) q.push_back('{pc: pc, pred: pr, tgt: pt});
      @(posedge clk);
      #1;
      check_outputs();
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic push_br(input logic [31:0] pc, input logic pr, input logic [31:0] pt);
      step(1'b1, pc, pr, pt, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic resolve_br(input logic tk, input logic [31:0] tg);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, tk, tg);
   endtask

   // Reset wins over a same-cycle push and resolve
   task automatic do_reset();
      rst            = 1'b1;
      if_valid       = 1'b1;
      if_pc          = 32'h3000;
      if_pred        = 1'b0;
      if_pred_target = 32'h0;
      ex_valid       = 1'b1;
      ex_taken       = 1'b1;
      ex_target      = 32'h1234;
      @(posedge clk);
      #1;
      chk("rst_if_stall", if_stall, 1'b0);
      chk("rst_bht_en", bht_en, 1'b0);
      chk("rst_bht_write_addr", bht_write_addr, 5'h0);
      chk("rst_bht_was_taken", bht_was_taken, 1'b0);
      chk("rst_flush", flush, 1'b0);
      chk("rst_redirect_pc", redirect_pc, 32'h0);
      chk("rst_err_underflow", err_underflow, 1'b0);
      chk("rst_branch_cnt", branch_cnt, 4'h0);
      chk("rst_mispred_cnt", mispred_cnt, 4'h0);
      model_clear();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      model_clear();
      @(negedge clk);
      do_reset();

      // Correct taken prediction
      push_br(32'h40, 1'b1, 32'h80);
      resolve_br(1'b1, 32'h80);
      chk("ok_bht_en", bht_en, 1'b1);
      chk("ok_addr", bht_write_addr, 5'h10);
      chk("ok_was_taken", bht_was_taken, 1'b1);
      chk("ok_flush", flush, 1'b0);
      chk("ok_mispred_cnt", mispred_cnt, 4'h0);
      idle();

      // Direction mispredict
      push_br(32'h44, 1'b0, 32'h0);
      resolve_br(1'b1, 32'h100);
      chk("dir_flush", flush, 1'b1);
      chk("dir_redirect", redirect_pc, 32'h100);
      chk("dir_addr", bht_write_addr, 5'h11);
      idle();

      // Target mispredict, then not-taken redirect to pc+4
      push_br(32'h48, 1'b1, 32'h90);
      resolve_br(1'b1, 32'hA0);
      chk("tgt_redirect", redirect_pc, 32'hA0);
      push_br(32'h4C, 1'b1, 32'h200);
      resolve_br(1'b0, 32'h0);
      chk("nt_redirect", redirect_pc, 32'h50);

      // pc+4 wraps modulo 2^32
      push_br(32'hFFFF_FFFC, 1'b1, 32'h10);
      resolve_br(1'b0, 32'h0);
      chk("wrap_redirect", redirect_pc, 32'h0);

      // Fill, overfill, then mispredict the head with a push in the same cycle
      for (int i = 0; i < DEPTH; i++) push_br(32'h100 + 32'(4 * i), 1'b0, 32'h0);
      push_br(32'h110, 1'b0, 32'h0);
      step(1'b1, 32'h114, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300);
      chk("full_flush", flush, 1'b1);
      chk("full_addr", bht_write_addr, 5'h0);
      chk("flush_stall", if_stall, 1'b0);
      resolve_br(1'b0, 32'h0);
      chk("underflow_set", err_underflow, 1'b1);
      chk("underflow_no_en", bht_en, 1'b0);

      // Simultaneous push/pop at occupancy 2 keeps program order
      push_br(32'h200, 1'b1, 32'h400);
      push_br(32'h204, 1'b0, 32'h0);
      step(1'b1, 32'h208, 1'b0, 32'h0, 1'b1, 1'b1, 32'h400);
      chk("pp_addr0", bht_write_addr, 5'h00);
      resolve_br(1'b0, 32'h0);
      chk("pp_addr1", bht_write_addr, 5'h01);
      resolve_br(1'b0, 32'h0);
      chk("pp_addr2", bht_write_addr, 5'h02);
      idle();

      // Mispredict on the cycle the flushed FIFO refills: new push is accepted
      push_br(32'h500, 1'b0, 32'h0);
      resolve_br(1'b1, 32'h700);
      push_br(32'h700, 1'b1, 32'h740);
      resolve_br(1'b1, 32'h740);
      chk("refill_flush", flush, 1'b0);

      // Counter saturation
      for (int i = 0; i < 20; i++) begin
         push_br(32'h600 + 32'(4 * i), 1'b0, 32'h0);
         resolve_br(1'b1, 32'h700);
      end
      chk("sat_mispred", mispred_cnt, 4'hF);
      chk("sat_branch", branch_cnt, 4'hF);

      // Reset with entries in flight: nothing emitted for them afterwards
      for (int i = 0; i < 3; i++) push_br(32'h800 + 32'(4 * i), 1'b1, 32'h900);
      do_reset();
      idle();
      chk("post_rst_no_en", bht_en, 1'b0);
      resolve_br(1'b1, 32'h900);
      chk("post_rst_underflow", err_underflow, 1'b1);
      do_reset();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic        iv;
         logic        ev;
         logic [31:0] pc;
         logic [31:0] pt;
         logic [31:0] tg;
         if ($urandom_range(0, 63) == 0) begin
            do_reset();
         end else begin
            iv = ($urandom_range(0, 9) < 6);
            ev = ($urandom_range(0, 9) < 5);
            pc = 32'h1000 + 32'(4 * $urandom_range(0, 31));
            pt = ($urandom_range(0, 1) == 1) ? 32'h800 : 32'h804;
            tg = ($urandom_range(0, 3) == 0) ? 32'h804 : 32'h800;
            step(iv, pc, 1'($urandom_range(0, 1)), pt, ev, ($urandom_range(0, 3) != 0), tg);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Tracks every branch prediction issued in fetch until the branch resolves in execute, detects mispredictions, and produces the registered update strobe that trains the 2-bit branch history table. Sits between the fetch stage and the BHT write port. It consumes the BHT `prediction` bit at fetch, and drives the BHT `write_addr`/`was_taken`/`en` inputs plus the pipeline flush/redirect.

## Interface
- `PC_W`, 32, program-counter width
- `IDX_W`, 5, BHT index width; index = `pc[IDX_W+1:2]`
- `DEPTH`, 4, in-flight branch entries; power of two, ≥2
- `CNT_W`, 16, statistics counter width

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, synchronous, active-high
- `if_valid` in 1: fetch presents a branch this cycle
- `if_pc` in PC_W: PC of that branch
- `if_pred` in 1: BHT prediction for `if_pc`
- `if_pred_target` in PC_W: predicted target, used when `if_pred`=1
- `if_stall` out 1: FIFO full; fetch must hold its branch
- `ex_valid` in 1: execute resolves the oldest branch this cycle
- `ex_taken` in 1: actual outcome
- `ex_target` in PC_W: actual taken target
- `bht_en` out 1: one-cycle BHT update strobe
- `bht_write_addr` out IDX_W: index to update
- `bht_was_taken` out 1: outcome to train with
- `flush` out 1: one-cycle mispredict flush
- `redirect_pc` out PC_W: correct fetch PC, valid while `flush`=1
- `err_underflow` out 1: sticky; set when a resolve arrives with the FIFO empty
- `branch_cnt` out CNT_W: resolved branches, saturating
- `mispred_cnt` out CNT_W: mispredictions, saturating

## Operation
- Each FIFO entry holds {pc, pred, pred_target}, kept in program order.
- **Push:**
  - Condition: `if_valid` && !`if_stall` && !mispredict-this-cycle.
  - When full, the push is ignored and fetch must hold its branch.
- **Resolve:**
  - Condition: `ex_valid` with the FIFO non-empty. The head entry is popped.
  - Mispredict = (pred != `ex_taken`) || (`ex_taken` && pred_target != `ex_target`).
- **Update:** every resolve produces one BHT update.
  - `bht_write_addr` = head pc[IDX_W+1:2].
  - `bht_was_taken` = `ex_taken`.
  - This happens regardless of mispredict.
- **Mispredict:**
  - `flush` is asserted.
  - `redirect_pc` = `ex_taken` ? `ex_target` : head pc + 4 (mod 2^PC_W).
  - The FIFO is cleared, because all younger entries are wrong-path.
  - A same-cycle push is dropped.
- **Correct prediction:** no flush. A same-cycle push and pop both take effect, and occupancy is unchanged.
- **Resolve while empty:** no update, no flush, counters unchanged, and `err_underflow` is set until `rst`.
- **Counters:** increment on resolve / on mispredict and saturate at all-ones.

## Timing
- All outputs are registered except `if_stall` = (count == DEPTH), which is combinational from state.
- `bht_en`, `bht_write_addr`, `bht_was_taken`, `flush` and `redirect_pc` appear the cycle after the `ex_valid` edge. `bht_en` and `flush` are high exactly one cycle.
- A pushed entry is resolvable the following cycle.
- Back-to-back resolves on consecutive cycles produce back-to-back `bht_en` pulses.
- After a mispredict, the FIFO is empty in the same cycle `flush` is high. An `if_valid` in that cycle is accepted, since it is the redirected path.
- **Reset:**
  - FIFO empty, pointers 0.
  - All outputs 0, including `if_stall`=0, `redirect_pc`=0, counters 0, `err_underflow`=0.
  - `rst` mid-operation discards in-flight entries, and no update is emitted for them.
- `rst` has priority over push and resolve.

## Structure
- Package `bp_pkg`:
  - Constants `PC_W`, `IDX_W`.
  - Typedef `bp_entry_t` {pc, pred, pred_target}.
  - Function `bht_index(pc)`.
- Sub-module `pred_fifo`:
  - Parameterised synchronous FIFO (DEPTH, entry width).
  - Has push/pop/clear, count, full/empty.
  - Clear has priority over push.
- The top level holds the compare logic, output registers and counters.

## Test plan
- **Correct prediction:** push pc=0x40, pred=1, target=0x80; resolve taken=1, target=0x80 → next cycle `bht_en`=1, addr=0x10, was_taken=1; `flush`=0; mispred_cnt=0.
- **Direction mispredict:** push pc=0x44, pred=0; resolve taken=1, target=0x100 → `flush`=1, `redirect_pc`=0x100, addr=0x11.
- **Target mispredict, not-taken redirect:**
  - Push pc=0x48, pred=1, target=0x90; resolve taken=1, target=0xA0 → `redirect_pc`=0xA0.
  - Push pc=0x4C, pred=1; resolve taken=0 → `redirect_pc`=0x50.
- **Full and flush:**
  - Push 4 branches → `if_stall`=1; a 5th push is ignored.
  - Mispredict the head with a same-cycle push → FIFO empties, `if_stall`=0, and the following resolve sets `err_underflow`.
- **Simultaneous push/pop at occupancy 2:** correct prediction → occupancy stays 2, and pops return program order.
- **Counter saturation and reset:**
  - With CNT_W=4, run 20 mispredicts → mispred_cnt=15.
  - Assert `rst` with 3 entries → all outputs 0, and no `bht_en` follows.
